// File: rtl/lp_grid_solver.sv
// lp_grid_solver: two-variable integer LP solved by exhaustively scanning the
// bounding box implied by the axis-aligned constraints, one grid point per cycle.
module lp_grid_solver #(
    parameter int NCON  = 6,
    parameter int AW    = 6,
    parameter int BW    = 12,
    parameter int OW    = 16,
    parameter int XYLIM = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_mode,
    input  logic signed [AW-1:0] in_a1,
    input  logic signed [AW-1:0] in_a2,
    input  logic signed [BW-1:0] in_b,
    output logic                 out_valid,
    output logic                 out_feasible,
    output logic signed [OW-1:0] out_value,
    output logic signed [BW-1:0] out_x,
    output logic signed [BW-1:0] out_y
);
    localparam int SW = AW + BW + 2;
    localparam int CW = NCON > 1 ? $clog2(NCON) : 1;
    localparam logic signed [BW:0]   LIMW = (BW+1)'(XYLIM);
    localparam logic signed [BW-1:0] LIM  = BW'(XYLIM);
    localparam logic signed [BW-1:0] NLIM = BW'(-XYLIM);
    localparam logic signed [AW-1:0] ONE  = AW'(1);
    localparam logic signed [AW-1:0] MONE = '1;
    typedef enum logic [2:0] {IDLE, LOAD, BOUND, SCAN, OUT} state_t;
    state_t state_q;
    logic mode_q, found_q, found_d, take, feas, last_k, last_pt, empty;
    logic [CW-1:0] cnt_q;
    logic signed [AW-1:0] c1_q, c2_q, a1_k, a2_k;
    logic signed [AW-1:0] a1_q [NCON];
    logic signed [AW-1:0] a2_q [NCON];
    logic signed [BW-1:0] b_q [NCON];
    logic signed [BW-1:0] xlo_q, xhi_q, ylo_q, yhi_q, xlo_d, xhi_d, ylo_d, yhi_d;
    logic signed [BW-1:0] x_q, y_q, bx_q, by_q, bx_d, by_d, b_k;
    logic signed [SW-1:0] val, best_q, best_d;
    logic signed [OW-1:0] sat;

    function automatic logic signed [BW-1:0] clamp(input logic signed [BW:0] v);
        return v > LIMW ? LIM : v < -LIMW ? NLIM : v[BW-1:0];
    endfunction

    // Bound extraction looks at one stored constraint per cycle.
    assign a1_k   = a1_q[cnt_q];
    assign a2_k   = a2_q[cnt_q];
    assign b_k    = b_q[cnt_q];
    assign last_k = cnt_q == CW'(NCON - 1);
    assign xhi_d  = (a2_k == '0 && a1_k == ONE)  ? clamp((BW+1)'(b_k))    : xhi_q;
    assign xlo_d  = (a2_k == '0 && a1_k == MONE) ? clamp(-((BW+1)'(b_k))) : xlo_q;
    assign yhi_d  = (a1_k == '0 && a2_k == ONE)  ? clamp((BW+1)'(b_k))    : yhi_q;
    assign ylo_d  = (a1_k == '0 && a2_k == MONE) ? clamp(-((BW+1)'(b_k))) : ylo_q;
    assign empty  = xlo_d > xhi_d || ylo_d > yhi_d;

    always_comb begin
        feas = 1'b1;
        for (int k = 0; k < NCON; k++)
            if (SW'(a1_q[k]) * SW'(x_q) + SW'(a2_q[k]) * SW'(y_q) > SW'(b_q[k])) feas = 1'b0;
    end

    assign val     = SW'(c1_q) * SW'(x_q) + SW'(c2_q) * SW'(y_q);
    assign take    = feas && (!found_q || (mode_q ? val < best_q : val > best_q));
    assign found_d = found_q || take;
    assign best_d  = take ? val : best_q;
    assign bx_d    = take ? x_q : bx_q;
    assign by_d    = take ? y_q : by_q;
    assign last_pt = x_q == xhi_q && y_q == yhi_q;
    assign sat     = (&best_d[SW-1:OW-1] || ~|best_d[SW-1:OW-1]) ? best_d[OW-1:0]
                   : {best_d[SW-1], {(OW-1){~best_d[SW-1]}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            {mode_q, found_q, cnt_q, c1_q, c2_q} <= '0;
            for (int k = 0; k < NCON; k++) begin
                a1_q[k] <= '0;
                a2_q[k] <= '0;
                b_q[k]  <= '0;
            end
            {xlo_q, xhi_q, ylo_q, yhi_q, x_q, y_q, bx_q, by_q, best_q} <= '0;
            {out_valid, out_feasible, out_value, out_x, out_y} <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state_q)
                IDLE: if (in_valid) begin
                    {mode_q, c1_q, c2_q} <= {in_mode, in_a1, in_a2};
                    cnt_q   <= '0;
                    state_q <= LOAD;
                end
                LOAD: if (in_valid) begin
                    a1_q[cnt_q] <= in_a1;
                    a2_q[cnt_q] <= in_a2;
                    b_q[cnt_q]  <= in_b;
                    cnt_q       <= last_k ? '0 : cnt_q + 1'b1;
                    if (last_k) begin
                        {xlo_q, ylo_q} <= {NLIM, NLIM};
                        {xhi_q, yhi_q} <= {LIM, LIM};
                        state_q        <= BOUND;
                    end
                end
                BOUND: begin
                    {xlo_q, xhi_q, ylo_q, yhi_q} <= {xlo_d, xhi_d, ylo_d, yhi_d};
                    {x_q, y_q} <= {xlo_d, ylo_d};
                    found_q    <= 1'b0;
                    cnt_q      <= last_k ? '0 : cnt_q + 1'b1;
                    if (last_k) begin
                        state_q <= empty ? OUT : SCAN;
                        if (empty) begin
                            out_valid <= 1'b1;
                            {out_feasible, out_value, out_x, out_y} <= '0;
                        end
                    end
                end
                SCAN: begin
                    {found_q, best_q, bx_q, by_q} <= {found_d, best_d, bx_d, by_d};
                    x_q <= x_q == xhi_q ? xlo_q : x_q + 1'b1;
                    y_q <= x_q == xhi_q ? y_q + 1'b1 : y_q;
                    // Outputs take this cycle's update so the final point counts.
                    if (last_pt) begin
                        state_q      <= OUT;
                        out_valid    <= 1'b1;
                        out_feasible <= found_d;
                        out_value    <= found_d ? sat : '0;
                        out_x        <= found_d ? bx_d : '0;
                        out_y        <= found_d ? by_d : '0;
                    end
                end
                OUT:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lp_grid_solver.sv
// tb_lp_grid_solver: directed and randomized problems checked by a queue-based
// scoreboard against a brute-force grid search model.
module tb_lp_grid_solver;
    localparam int NCON = 6, AW = 6, BW = 12, OW = 16, XY = 8;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_mode = 1'b0;
    logic signed [AW-1:0] in_a1 = '0, in_a2 = '0;
    logic signed [BW-1:0] in_b = '0;
    logic out_valid, out_feasible;
    logic signed [OW-1:0] out_value;
    logic signed [BW-1:0] out_x, out_y;
    int compared = 0, mismatched = 0;
    longint cyc = 0;
    typedef struct {bit f; int v; int x; int y; longint t;} exp_t;
    exp_t sb[$];
    exp_t held, me;
    logic pmode;
    int pc1, pc2;
    int pa1[NCON], pa2[NCON], pb[NCON];
    int cons[NCON][3];

    lp_grid_solver #(.NCON(NCON), .AW(AW), .BW(BW), .OW(OW), .XYLIM(XY)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_mode(in_mode),
        .in_a1(in_a1), .in_a2(in_a2), .in_b(in_b), .out_valid(out_valid),
        .out_feasible(out_feasible), .out_value(out_value), .out_x(out_x), .out_y(out_y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    function automatic int clip(input int v);
        return v > XY ? XY : v < -XY ? -XY : v;
    endfunction

    // Reference: derive the box, then try every point in scan order.
    function automatic exp_t model();
        int xlo = -XY, xhi = XY, ylo = -XY, yhi = XY, best = 0, v;
        bit ok;
        exp_t e;
        e.f = 0; e.v = 0; e.x = 0; e.y = 0; e.t = 0;
        for (int k = 0; k < NCON; k++) begin
            if (pa1[k] == 0 && pa2[k] == 1)  yhi = clip(pb[k]);
            if (pa1[k] == 0 && pa2[k] == -1) ylo = clip(-pb[k]);
            if (pa2[k] == 0 && pa1[k] == 1)  xhi = clip(pb[k]);
            if (pa2[k] == 0 && pa1[k] == -1) xlo = clip(-pb[k]);
        end
        if (xlo <= xhi && ylo <= yhi) e.t = (xhi - xlo + 1) * (yhi - ylo + 1);
        for (int y = ylo; y <= yhi; y++)
            for (int x = xlo; x <= xhi; x++) begin
                ok = 1;
                for (int k = 0; k < NCON; k++) if (pa1[k] * x + pa2[k] * y > pb[k]) ok = 0;
                v = pc1 * x + pc2 * y;
                if (ok && (!e.f || (pmode ? v < best : v > best))) begin
                    e.f = 1; best = v; e.x = x; e.y = y;
                end
            end
        e.v = best > 32767 ? 32767 : best < -32768 ? -32768 : best;
        return e;
    endfunction

    task automatic junk(input logic v);
        in_valid = v;
        in_mode  = 1'($urandom);
        in_a1    = AW'($urandom);
        in_a2    = AW'($urandom);
        in_b     = BW'($urandom);
    endtask

    task automatic load(input logic m, input int c1, input int c2);
        pmode = m; pc1 = c1; pc2 = c2;
        for (int k = 0; k < NCON; k++) begin
            pa1[k] = cons[k][0]; pa2[k] = cons[k][1]; pb[k] = cons[k][2];
        end
    endtask

    // Push the expectation at the last beat; if pushed, wait out the run with
    // junk on the inputs (must be ignored) and return in the OUT cycle.
    task automatic send(input bit push, input bit gaps);
        exp_t e = model();
        longint t;
        @(negedge clk);
        junk(1'b1); in_mode = pmode; in_a1 = AW'(pc1); in_a2 = AW'(pc2);
        for (int k = 0; k < NCON; k++) begin
            if (gaps && $urandom_range(0, 2) == 0)
                repeat ($urandom_range(1, 2)) begin @(negedge clk); junk(1'b0); end
            @(negedge clk);
            junk(1'b1); in_a1 = AW'(pa1[k]); in_a2 = AW'(pa2[k]); in_b = BW'(pb[k]);
        end
        t = cyc + NCON + e.t + 1;
        e.t = t;
        held = e;
        if (!push) begin
            @(negedge clk);
            junk(1'b0);
            return;
        end
        sb.push_back(e);
        do begin
            @(negedge clk);
            junk(cyc < t ? 1'($urandom) : 1'b0);
        end while (cyc < t);
    endtask

    task automatic rand_prob();
        int r;
        pmode = 1'($urandom);
        pc1 = int'($urandom_range(0, 63)) - 32;
        pc2 = int'($urandom_range(0, 63)) - 32;
        for (int k = 0; k < NCON; k++) begin
            r = int'($urandom_range(0, 24)) - 12;
            case ($urandom_range(0, 5))
                0: cons[k] = '{1, 0, r};
                1: cons[k] = '{-1, 0, r};
                2: cons[k] = '{0, 1, r};
                3: cons[k] = '{0, -1, r};
                4: cons[k] = '{int'($urandom_range(0, 10)) - 5, int'($urandom_range(0, 10)) - 5,
                               int'($urandom_range(0, 80)) - 40};
                default: cons[k] = '{int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32,
                                     int'($urandom_range(0, 4095)) - 2048};
            endcase
        end
        load(pmode, pc1, pc2);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_feasible"}, out_feasible, 0);
        chk({tag, "_value"}, out_value, 0);
        chk({tag, "_x"}, out_x, 0);
        chk({tag, "_y"}, out_y, 0);
    endtask

    initial forever begin
        @(negedge clk);
        if (out_valid) begin
            if (sb.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL spurious_out_valid: got 1, expected 0 (cycle %0d)", cyc);
            end else begin
                me = sb.pop_front();
                chk("latency", cyc, me.t);
                chk("feasible", out_feasible, me.f);
                chk("value", out_value, me.v);
                chk("x", out_x, me.x);
                chk("y", out_y, me.y);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        junk(1'b0);
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        cons = '{'{1, 0, 4}, '{-1, 0, 0}, '{0, 1, 5}, '{0, -1, 0}, '{1, 1, 6}, '{2, 1, 10}};
        load(1'b0, 3, 2); send(1, 0);
        load(1'b1, 3, 2); send(1, 0);
        cons = '{'{1, 0, 2}, '{-1, 0, -5}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
        load(1'b0, 1, 1); send(1, 0);
        cons = '{'{1, 0, 3}, '{-1, 0, 0}, '{0, 1, 3}, '{0, -1, 0}, '{1, 1, 3}, '{1, 1, 3}};
        load(1'b0, 1, 1); send(1, 0);
        cons = '{'{1, 0, -1}, '{-1, 0, 3}, '{0, 1, -2}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
        load(1'b0, -1, -1); send(1, 0);
        repeat (3) @(negedge clk);
        chk("hold_feasible", out_feasible, held.f);
        chk("hold_value", out_value, held.v);
        chk("hold_x", out_x, held.x);
        chk("hold_y", out_y, held.y);
        // Abort a problem mid-scan, then rerun it from scratch.
        cons = '{'{1, 0, 4}, '{-1, 0, 0}, '{0, 1, 5}, '{0, -1, 0}, '{1, 1, 6}, '{2, 1, 10}};
        load(1'b0, 3, 2); send(0, 0);
        repeat (NCON + 10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("midscan_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send(1, 0);
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            rand_prob();
            send(1, 1);
        end
        repeat (400) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            compared++; mismatched++;
            $display("FAIL drain: got %0d pending results, expected 0", sb.size());
        end
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
